fft_io_sequencer: RTL and testbench
===================================

# fft_io_sequencer

Host-side sequencer for the 2048-point FFT core (4 RAM banks × 512 words). It accepts a real sample stream and writes it into the core's host port in bank-interleaved order, then pulses the core start. It waits for completion and streams the 2048 real results back out with valid/ready backpressure. It sits between the system stream fabric and the core's iDATA / iADDR_* / iWE_* / iSTART / oRDY / oDATA_RE_* pins.

## Interface
- BANK_AW, 9: bank address width; frame length N = 4·2^BANK_AW (2048).
- TIMEOUT, 65535: maximum cycles in RUN before an error is flagged.
- iCLK  in  1  clock.
- iRESET  in  1  asynchronous, active-high reset.
- iS_DATA  in  16  input sample.
- iS_VALID  in  1  input sample valid.
- oS_READY  out  1  sequencer accepts a sample this cycle.
- oM_DATA  out  17  result sample (core real output, passed through unchanged).
- oM_VALID  out  1  result valid.
- iM_READY  in  1  downstream accepts the result.
- oM_LAST  out  1  marks the final result (index N-1).
- oFFT_DATA  out  16  to core iDATA.
- oADDR_WR_0..3  out  BANK_AW  to core iADDR_WR_0..3.
- oWE_0..3  out  1  to core iWE_0..3.
- oADDR_RD_0..3  out  BANK_AW  to core iADDR_RD_0..3.
- iDATA_RE_0..3  in  17  from core oDATA_RE_0..3; registered read, 1-cycle latency.
- oFFT_START  out  1  to core iSTART; one-cycle pulse.
- iFFT_RDY  in  1  from core oRDY; one-cycle pulse when the transform is complete.
- oBUSY  out  1  high in every state except IDLE.
- oERR  out  1  sticky RUN timeout flag; cleared only by reset.

## Operation
- Sample index k (11 bits) maps to bank k[1:0] and address k[10:2]. Load and unload use this same natural order; reordering is not done here.
- States and transitions:
  - IDLE → LOAD on the first iS_VALID.
  - LOAD → START after sample N-1 is written.
  - START → RUN after one cycle.
  - RUN → UNLOAD on iFFT_RDY.
  - RUN → IDLE on timeout, setting oERR.
  - UNLOAD → IDLE when oM_LAST is accepted.
- IDLE/LOAD:
  - oS_READY = 1.
  - On iS_VALID: oFFT_DATA = iS_DATA; the selected oWE_b = 1 and all other WE = 0; all four oADDR_WR carry k[10:2]; k increments.
  - Registered outputs: the write appears one cycle after acceptance.
- START:
  - oS_READY = 0. oFFT_START = 1 for exactly one cycle.
  - This cycle follows the cycle in which the final write was driven, so there is one idle gap after the last WE.
- RUN:
  - oS_READY = 0; all WE = 0.
  - A cycle counter runs. Reaching TIMEOUT sets oERR and returns to IDLE without unloading.
  - iFFT_RDY in any state other than RUN is ignored.
- UNLOAD:
  - A read is issued for index r: all oADDR_RD_x = r[10:2], and a bank tag r[1:0] is piped alongside.
  - The returned word is taken from iDATA_RE_{tag} one cycle later and placed in a 2-entry output FIFO.
  - A read issues only when (FIFO occupancy + reads in flight) < 2 and r < N.
  - Head of FIFO drives oM_DATA / oM_VALID. oM_LAST = 1 when the head index is N-1.
  - Pop on oM_VALID & iM_READY. oM_DATA holds stable while oM_VALID & !iM_READY.
- Counters wrap at N; a new frame restarts k = r = 0.
- iS_VALID during START/RUN/UNLOAD is not accepted (oS_READY = 0); no sample is lost or written.
- Reset mid-operation: return immediately to IDLE, clear counters, FIFO and oERR. The core RAM contents are undefined; the next frame overwrites all N words.

## Timing
- Reset values:
  - oS_READY = 0 (rises 1 cycle after reset release).
  - oM_VALID, oM_LAST, oWE_*, oFFT_START, oBUSY, oERR = 0.
  - All addresses and data = 0.
- Load throughput: 1 sample/cycle. A sample accepted at cycle t is written at t+1.
- oFFT_START asserts 2 cycles after the last sample is accepted.
- Unload:
  - First oM_VALID appears 3 cycles after iFFT_RDY: one cycle to enter UNLOAD and issue the read, one cycle of RAM latency, one cycle for FIFO registration.
  - Sustained 1 result/cycle with iM_READY held high.
- oBUSY falls the cycle after the oM_LAST handshake.

## Test plan
- Ramp load: iS_DATA = k for 2048 samples with iS_VALID always high → WE one-hot cycling 0,1,2,3. Address 0 is held for 4 writes, then advances to 1. oFFT_START pulses once, 2 cycles after the last accept.
- Core model echoing RAM (iFFT_RDY 100 cycles after start), iM_READY = 1 → 2048 outputs equal to {1'b0, k} in order. oM_LAST only on 0x7FF. Back-to-back valid after the 3-cycle initial latency.
- Random iM_READY at 30% → output sequence identical to the previous test, no duplicates or drops, oM_DATA stable while stalled.
- iFFT_RDY withheld, TIMEOUT = 50 → oERR = 1 at RUN cycle 50, state returns to IDLE, oS_READY = 1, no oM_VALID.
- Reset asserted at load sample 1000 → all outputs zero asynchronously. The next frame starts writing at bank 0, address 0.
- iS_VALID held high during RUN/UNLOAD plus a spurious iFFT_RDY during LOAD → no WE asserted outside LOAD, and the LOAD sequence is unaffected.

Source files
------------

// File: rtl/fft_io_sequencer_if.sv
// Host-side bus bundle of the FFT I/O sequencer: sample stream in, result stream out,
// and the FFT core host-port pins. master = sequencer, slave = surrounding system/core.
interface fft_io_sequencer_if #(
    parameter int BANK_AW = 9
);
    logic [15:0]        iS_DATA;
    logic               iS_VALID;
    logic               oS_READY;

    logic [16:0]        oM_DATA;
    logic               oM_VALID;
    logic               iM_READY;
    logic               oM_LAST;

    logic [15:0]        oFFT_DATA;
    logic [BANK_AW-1:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
    logic               oWE_0, oWE_1, oWE_2, oWE_3;
    logic [BANK_AW-1:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
    logic [16:0]        iDATA_RE_0, iDATA_RE_1, iDATA_RE_2, iDATA_RE_3;
    logic               oFFT_START;
    logic               iFFT_RDY;
    logic               oBUSY;
    logic               oERR;

    modport master (
        input  iS_DATA, iS_VALID, iM_READY, iFFT_RDY,
               iDATA_RE_0, iDATA_RE_1, iDATA_RE_2, iDATA_RE_3,
        output oS_READY, oM_DATA, oM_VALID, oM_LAST, oFFT_DATA,
               oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
               oWE_0, oWE_1, oWE_2, oWE_3,
               oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
               oFFT_START, oBUSY, oERR
    );

    modport slave (
        output iS_DATA, iS_VALID, iM_READY, iFFT_RDY,
               iDATA_RE_0, iDATA_RE_1, iDATA_RE_2, iDATA_RE_3,
        input  oS_READY, oM_DATA, oM_VALID, oM_LAST, oFFT_DATA,
               oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
               oWE_0, oWE_1, oWE_2, oWE_3,
               oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
               oFFT_START, oBUSY, oERR
    );
endinterface

// File: rtl/fft_io_sequencer.sv
// Loads one frame of samples into the FFT core's banked RAM, starts the transform,
// waits for completion (with timeout) and streams the results out through a 2-deep FIFO.
module fft_io_sequencer #(
    parameter int BANK_AW = 9,
    parameter int TIMEOUT = 65535
) (
    input  logic               iCLK,
    input  logic               iRESET,
    fft_io_sequencer_if.master bus
);
    localparam int N  = 4 << BANK_AW;
    localparam int KW = BANK_AW + 2;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_UNLOAD = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [KW:0]        r_q, r_d;           // one extra bit so r == N means "all reads issued"
    logic [TW-1:0]      run_q, run_d;
    logic               err_q, err_d;
    logic               s_ready_q, s_ready_d;
    logic               busy_q, busy_d;
    logic               start_q, start_d;
    logic [3:0]         we_q, we_d;
    logic [BANK_AW-1:0] addr_wr_q, addr_wr_d;
    logic [15:0]        data_q, data_d;
    logic               rd_vld_q, rd_vld_d;
    logic [1:0]         rd_tag_q, rd_tag_d;
    logic               rd_last_q, rd_last_d;
    logic [17:0]        fifo_q [2];
    logic [17:0]        fifo_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         occ_q, occ_d;

    logic        accept, pop, issue, m_valid;
    logic [1:0]  occ_after;
    logic [17:0] head;
    logic [16:0] rd_data;

    assign head      = fifo_q[rd_ptr_q];
    assign m_valid   = (occ_q != 2'd0);
    assign accept    = s_ready_q & bus.iS_VALID;
    assign pop       = m_valid & bus.iM_READY;
    // Credit the slot freed by this cycle's pop so a full-rate stream never stalls.
    assign occ_after = occ_q - {1'b0, pop};
    assign issue     = (state_q == S_UNLOAD) && (r_q < (KW+1)'(N)) &&
                       ((occ_after + {1'b0, rd_vld_q}) < 2'd2);

    always_comb begin
        case (rd_tag_q)
            2'd0:    rd_data = bus.iDATA_RE_0;
            2'd1:    rd_data = bus.iDATA_RE_1;
            2'd2:    rd_data = bus.iDATA_RE_2;
            default: rd_data = bus.iDATA_RE_3;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default here; without it a missed branch infers a latch.
        state_d   = state_q;
        k_d       = k_q;
        r_d       = r_q;
        run_d     = run_q;
        err_d     = err_q;
        we_d      = '0;
        addr_wr_d = addr_wr_q;
        data_d    = data_q;
        start_d   = 1'b0;
        rd_vld_d  = 1'b0;
        rd_tag_d  = rd_tag_q;
        rd_last_d = rd_last_q;
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;

        if (accept) begin
            we_d      = 4'b0001 << k_q[1:0];
            addr_wr_d = k_q[KW-1:2];
            data_d    = bus.iS_DATA;
            k_d       = k_q + 1'b1;
            if (state_q == S_IDLE) state_d = S_LOAD;
            if (k_q == KW'(N - 1)) state_d = S_START;
        end

        case (state_q)
            S_START: begin
                start_d = 1'b1;
                run_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (bus.iFFT_RDY) begin
                    r_d     = '0;
                    state_d = S_UNLOAD;
                end else if (run_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    run_d = run_q + 1'b1;
                end
            end
            S_UNLOAD: begin
                if (issue) begin
                    rd_vld_d  = 1'b1;
                    rd_tag_d  = r_q[1:0];
                    rd_last_d = (r_q == (KW+1)'(N - 1));
                    r_d       = r_q + 1'b1;
                end
                if (pop && head[17]) begin
                    r_d     = '0;
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        if (rd_vld_q) begin
            fifo_d[wr_ptr_q] = {rd_last_q, rd_data};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        occ_d = occ_q + {1'b0, rd_vld_q} - {1'b0, pop};

        s_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
        busy_d    = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            r_q       <= '0;
            run_q     <= '0;
            err_q     <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            we_q      <= '0;
            addr_wr_q <= '0;
            data_q    <= '0;
            rd_vld_q  <= 1'b0;
            rd_tag_q  <= '0;
            rd_last_q <= 1'b0;
            // NOTE: the two FIFO words are reset because the head drives oM_DATA directly.
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            r_q       <= r_d;
            run_q     <= run_d;
            err_q     <= err_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            we_q      <= we_d;
            addr_wr_q <= addr_wr_d;
            data_q    <= data_d;
            rd_vld_q  <= rd_vld_d;
            rd_tag_q  <= rd_tag_d;
            rd_last_q <= rd_last_d;
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
        end
    end

    assign bus.oS_READY   = s_ready_q;
    assign bus.oM_DATA    = head[16:0];
    assign bus.oM_VALID   = m_valid;
    assign bus.oM_LAST    = m_valid & head[17];
    assign bus.oFFT_DATA  = data_q;
    assign bus.oADDR_WR_0 = addr_wr_q;
    assign bus.oADDR_WR_1 = addr_wr_q;
    assign bus.oADDR_WR_2 = addr_wr_q;
    assign bus.oADDR_WR_3 = addr_wr_q;
    assign bus.oWE_0      = we_q[0];
    assign bus.oWE_1      = we_q[1];
    assign bus.oWE_2      = we_q[2];
    assign bus.oWE_3      = we_q[3];
    assign bus.oADDR_RD_0 = r_q[KW-1:2];
    assign bus.oADDR_RD_1 = r_q[KW-1:2];
    assign bus.oADDR_RD_2 = r_q[KW-1:2];
    assign bus.oADDR_RD_3 = r_q[KW-1:2];
    assign bus.oFFT_START = start_q;
    assign bus.oBUSY      = busy_q;
    assign bus.oERR       = err_q;
endmodule

// File: tb/tb_fft_io_sequencer.sv
// Randomized bench for fft_io_sequencer: an echoing core RAM model plus a frame-level
// reference (sample queue, write schedule, start/timeout/unload timing) checked every cycle.
module tb_fft_io_sequencer;
    localparam int AW = 9;
    localparam int N  = 4 << AW;
    localparam int TO = 50;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_err;

    fft_io_sequencer_if #(.BANK_AW(AW)) bus ();

    fft_io_sequencer #(.BANK_AW(AW), .TIMEOUT(TO)) dut (
        .iCLK   (clk),
        .iRESET (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: plain banked RAM, registered read, result = {0, stored sample}.
    logic [15:0] ram [4][N/4];
    always @(posedge clk) begin
        if (bus.oWE_0) ram[0][bus.oADDR_WR_0] <= bus.oFFT_DATA;
        if (bus.oWE_1) ram[1][bus.oADDR_WR_1] <= bus.oFFT_DATA;
        if (bus.oWE_2) ram[2][bus.oADDR_WR_2] <= bus.oFFT_DATA;
        if (bus.oWE_3) ram[3][bus.oADDR_WR_3] <= bus.oFFT_DATA;
        bus.iDATA_RE_0 <= {1'b0, ram[0][bus.oADDR_RD_0]};
        bus.iDATA_RE_1 <= {1'b0, ram[1][bus.oADDR_RD_1]};
        bus.iDATA_RE_2 <= {1'b0, ram[2][bus.oADDR_RD_2]};
        bus.iDATA_RE_3 <= {1'b0, ram[3][bus.oADDR_RD_3]};
    end

    typedef struct {
        int          due;
        int          k;
        logic [15:0] d;
    } wr_t;

    wr_t         wr_q[$];
    logic [15:0] frame_buf[$];
    logic [15:0] exp_out[$];
    int model_k, out_idx, start_due, rdy_fire, rdy_cyc, to_due, last_pop, spur_k;
    bit src_on, ramp, hold, loaded, first_seen, err_model, stall_prev;
    int vpct, rpct, rdly;
    logic [16:0] prev_data;

    task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, {bus.oWE_3, bus.oWE_2, bus.oWE_1, bus.oWE_0}, '0);
        check({tag, "_ctl"}, {bus.oS_READY, bus.oM_VALID, bus.oM_LAST, bus.oFFT_START,
                              bus.oBUSY, bus.oERR}, '0);
        check({tag, "_dat"}, {bus.oFFT_DATA, bus.oM_DATA}, '0);
        check({tag, "_adr"}, {bus.oADDR_WR_0, bus.oADDR_WR_1, bus.oADDR_WR_2, bus.oADDR_WR_3,
                              bus.oADDR_RD_0, bus.oADDR_RD_1, bus.oADDR_RD_2, bus.oADDR_RD_3}, '0);
    endtask

    task automatic clear_model();
        wr_q.delete();
        frame_buf.delete();
        exp_out.delete();
        model_k    = 0;
        out_idx    = 0;
        start_due  = -1;
        rdy_fire   = -1;
        to_due     = -1;
        last_pop   = -10;
        err_model  = 1'b0;
        stall_prev = 1'b0;
        first_seen = 1'b0;
        src_on     = 1'b0;
        spur_k     = -1;
    endtask

    // One cycle: check everything the DUT shows now, then drive inputs for the next edge.
    task automatic step();
        wr_t  e;
        logic [3:0] we_v;
        bit   valid, ready, rdy, acc;
        @(negedge clk);
        we_v = {bus.oWE_3, bus.oWE_2, bus.oWE_1, bus.oWE_0};
        if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
            e = wr_q.pop_front();
            check("we", we_v, 4'b0001 << e.k[1:0]);
            check("addr_wr", {bus.oADDR_WR_3, bus.oADDR_WR_2, bus.oADDR_WR_1, bus.oADDR_WR_0},
                  {4{AW'(e.k >> 2)}});
            check("data_wr", bus.oFFT_DATA, e.d);
        end else begin
            check("we_idle", we_v, 4'b0000);
        end

        check("start", bus.oFFT_START, cyc == start_due);
        if (bus.oFFT_START) begin
            if (rdly >= 0) rdy_fire = cyc + rdly;
            else           to_due   = cyc + TO;
        end
        if (cyc == to_due) begin
            err_model = 1'b1;
            exp_out.delete();
            check("to_ready", bus.oS_READY, 1'b1);
            check("to_busy", bus.oBUSY, 1'b0);
        end
        check("err", bus.oERR, err_model);

        if (stall_prev) check("hold", bus.oM_DATA, prev_data);
        if (bus.oM_VALID) begin
            if (!first_seen) begin
                first_seen = 1'b1;
                check("latency", cyc - rdy_cyc, 3);
            end
            if (exp_out.size() == 0) begin
                check("out_extra", bus.oM_VALID, 1'b0);
            end else begin
                check("out_data", bus.oM_DATA, {1'b0, exp_out[0]});
                check("out_last", bus.oM_LAST, out_idx == N - 1);
            end
        end else if (rpct == 100 && first_seen && out_idx < N) begin
            check("gap", bus.oM_VALID, 1'b1);
        end
        if (cyc == last_pop + 1) check("busy_fall", bus.oBUSY, 1'b0);

        ready = ($urandom_range(99) < rpct);
        bus.iM_READY = ready;
        if (bus.oM_VALID && ready) begin
            if (exp_out.size() > 0) void'(exp_out.pop_front());
            if (out_idx == N - 1) begin
                check("busy_last", bus.oBUSY, 1'b1);
                last_pop = cyc;
            end
            out_idx++;
        end
        stall_prev = bus.oM_VALID && !ready;
        prev_data  = bus.oM_DATA;

        valid = src_on && (hold || !loaded) && ($urandom_range(99) < vpct);
        bus.iS_VALID = valid;
        bus.iS_DATA  = ramp ? 16'(model_k) : 16'($urandom);
        acc = valid && bus.oS_READY;
        if (acc) begin
            e.due = cyc + 1;
            e.k   = model_k;
            e.d   = bus.iS_DATA;
            wr_q.push_back(e);
            frame_buf.push_back(bus.iS_DATA);
            model_k++;
            if (model_k == N) begin
                model_k   = 0;
                loaded    = 1'b1;
                start_due = cyc + 2;
                exp_out   = frame_buf;
                frame_buf.delete();
            end
        end

        rdy = (cyc == rdy_fire);
        if (rdy) rdy_cyc = cyc;
        if (spur_k >= 0 && model_k == spur_k && !loaded) begin
            rdy    = 1'b1;
            spur_k = -1;
        end
        bus.iFFT_RDY = rdy;
    endtask

    task automatic run_frame(input bit r_ramp, input int v_pct, input int r_pct, input int dly,
                             input bit h, input int spur, input int abort_k);
        bit done;
        ramp = r_ramp; vpct = v_pct; rpct = r_pct; rdly = dly; hold = h; spur_k = spur;
        loaded = 1'b0; first_seen = 1'b0; out_idx = 0;
        rdy_fire = -1; to_due = -1; start_due = -1;
        src_on = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            step();
            if (abort_k >= 0)   done = (model_k == abort_k);
            else if (dly >= 0)  done = (out_idx == N);
            else                done = (to_due >= 0 && cyc > to_due + 3);
        end
        src_on = 1'b0;
        check("frame_done", done, 1'b1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        rst = 1'b1;
        bus.iS_DATA = '0; bus.iS_VALID = 1'b0; bus.iM_READY = 1'b0; bus.iFFT_RDY = 1'b0;
        ramp = 1'b0; hold = 1'b0; loaded = 1'b0; vpct = 0; rpct = 100; rdly = -1;
        rdy_cyc = 0; prev_data = '0;
        clear_model();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        check("ready_low", bus.oS_READY, 1'b0);
        @(negedge clk);
        check("ready_rise", bus.oS_READY, 1'b1);

        // Ramp, full-rate both sides, valid held high through RUN/UNLOAD.
        run_frame(1'b1, 100, 100, 40, 1'b1, -1, -1);
        repeat (4) step();
        // Ramp again with 30% downstream ready and a spurious iFFT_RDY mid-load.
        run_frame(1'b1, 100, 30, 40, 1'b1, 700, -1);
        repeat (4) step();
        // Random data with gappy input and output.
        run_frame(1'b0, 70, 60, 25, 1'b0, -1, -1);
        repeat (4) step();
        // Core never completes: timeout, sticky error, no unload.
        run_frame(1'b0, 100, 100, -1, 1'b0, -1, -1);
        repeat (6) step();
        check("err_sticky", bus.oERR, 1'b1);

        // Reset in the middle of a load.
        run_frame(1'b1, 100, 100, 40, 1'b0, -1, 1000);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_reset");
        clear_model();
        bus.iS_VALID = 1'b0; bus.iFFT_RDY = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("ready_low2", bus.oS_READY, 1'b0);
        // Fresh frame must start at bank 0, address 0.
        run_frame(1'b0, 100, 100, 40, 1'b0, -1, -1);
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
